// File: rtl/apb_timer_slave.sv
// APB2 down-counting timer slave: CTRL/LOAD/VALUE/STATUS registers, one-shot or periodic expiry, level IRQ.
// Optional prescaler is built when TIMER_PRESCALER_EN is defined; the default build has none.
module apb_timer_slave #(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 16
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Tirq
);

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_LOAD   = 3'd1;
    localparam logic [2:0] ADDR_VALUE  = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_PRESC  = 3'd4;

    logic [2:0]       reg_addr;
    logic             wr_en;
    logic             rd_setup;
    logic             wr_ctrl;
    logic             wr_load;
    logic             wr_status;
    logic             wr_presc;
    logic             ctrl_en;
    logic             ctrl_periodic;
    logic             ctrl_ie;
    logic [CNT_W-1:0] load_r;
    logic [CNT_W-1:0] value_r;
    logic             expired;
    logic             tick;
    logic             expire;
    logic [31:0]      presc_rd;
    logic [31:0]      rdata_mux;
    logic             unused_bits;

    assign reg_addr  = Paddr[4:2];
    assign wr_en     = Psel & Penable & Pwrite;
    assign rd_setup  = Psel & ~Penable & ~Pwrite;
    assign wr_ctrl   = wr_en && (reg_addr == ADDR_CTRL);
    assign wr_load   = wr_en && (reg_addr == ADDR_LOAD);
    assign wr_status = wr_en && (reg_addr == ADDR_STATUS);
    assign wr_presc  = wr_en && (reg_addr == ADDR_PRESC);

    assign unused_bits = &{1'b0, Paddr[31:5], Paddr[1:0], Pwdata, wr_presc};

`ifdef TIMER_PRESCALER_EN
    logic [PRESC_W-1:0] presc_r;
    logic [PRESC_W-1:0] presc_cnt;

    assign tick     = ctrl_en && (presc_cnt == presc_r);
    assign presc_rd = 32'(presc_r);

    // Count restarts from 0 whenever the timer is stopped or the divide ratio changes.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            presc_r   <= '0;
            presc_cnt <= '0;
        end else begin
            if (wr_presc) begin
                presc_r <= Pwdata[PRESC_W-1:0];
            end
            if (!ctrl_en || wr_presc) begin
                presc_cnt <= '0;
            end else if (presc_cnt == presc_r) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + PRESC_W'(1);
            end
        end
    end
`else
    assign tick     = ctrl_en;
    assign presc_rd = 32'd0;
`endif

    assign expire = tick && (value_r == CNT_W'(1));

    always_comb begin
        rdata_mux = 32'd0;
        case (reg_addr)
            ADDR_CTRL:   rdata_mux = 32'({ctrl_ie, ctrl_periodic, ctrl_en});
            ADDR_LOAD:   rdata_mux = 32'(load_r);
            ADDR_VALUE:  rdata_mux = 32'(value_r);
            ADDR_STATUS: rdata_mux = 32'(expired);
            ADDR_PRESC:  rdata_mux = presc_rd;
            default:     rdata_mux = 32'd0;
        endcase
    end

    // Later assignments deliberately override earlier ones: bus writes beat the
    // counter, and a fresh expiry beats a same-cycle W1C.
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            ctrl_en       <= 1'b0;
            ctrl_periodic <= 1'b0;
            ctrl_ie       <= 1'b0;
            load_r        <= '0;
            value_r       <= '0;
            expired       <= 1'b0;
            Prdata        <= 32'd0;
            Tirq          <= 1'b0;
        end else begin
            Prdata <= rd_setup ? rdata_mux : 32'd0;
            Tirq   <= expired & ctrl_ie;

            if (tick && (value_r != '0)) begin
                if (value_r == CNT_W'(1)) begin
                    if (ctrl_periodic) begin
                        value_r <= load_r;
                    end else begin
                        value_r <= '0;
                        ctrl_en <= 1'b0;
                    end
                end else begin
                    value_r <= value_r - CNT_W'(1);
                end
            end

            if (wr_ctrl) begin
                ctrl_en       <= Pwdata[0];
                ctrl_periodic <= Pwdata[1];
                ctrl_ie       <= Pwdata[2];
            end

            if (wr_load) begin
                load_r  <= Pwdata[CNT_W-1:0];
                value_r <= Pwdata[CNT_W-1:0];
            end

            if (wr_status && Pwdata[0]) begin
                expired <= 1'b0;
            end
            if (expire) begin
                expired <= 1'b1;
            end
        end
    end

endmodule

// File: doc/apb_timer_slave.md
# apb_timer_slave

APB peripheral sitting directly downstream of the AHB-to-APB bridge: it consumes one bit of the bridge's `Pselx` together with `Penable`, `Pwrite`, `Paddr` and `Pwdata`, and returns `Prdata`. It implements a memory-mapped down-counting timer with one-shot and periodic modes, a sticky expiry flag and an interrupt output. APB2-style protocol applies: there is no `Pready` and no `Pslverr`, so every access completes in exactly two cycles (setup, then access).

## Interface
- `CNT_W`, 32: counter and LOAD width (1..32); upper `Prdata` bits read 0.
- `PRESC_W`, 16: prescaler register width (used only with `TIMER_PRESCALER_EN`).
- `Hclk` in 1: single clock; all flops are rising-edge.
- `Hreset` in 1: synchronous, active-high reset.
- `Psel` in 1: this slave's select, driven from one bit of the bridge's `Pselx`.
- `Penable` in 1: APB access phase.
- `Pwrite` in 1: 1 = write, 0 = read.
- `Paddr` in 32: only `Paddr[4:2]` is decoded; other bits are ignored.
- `Pwdata` in 32: write data.
- `Prdata` out 32: registered read data.
- `Tirq` out 1: interrupt, level, = `EXPIRED & IE`, driven from flops.

## Operation
- Register map (offset, `Paddr[4:2]`):
  - 0x00 CTRL (RW): bit0 EN, bit1 PERIODIC, bit2 IE.
  - 0x04 LOAD (RW).
  - 0x08 VALUE (RO).
  - 0x0C STATUS: bit0 EXPIRED; write 1 to clear.
  - 0x10 PRESCALE (RW; see Configuration).
  - Other offsets read 0; writes to them are ignored. Writes to VALUE are ignored. Unused bits read 0.
- Write commit: on the edge where `Psel & Penable & Pwrite`.
- A LOAD write also copies the written value into VALUE.
- Tick: every cycle while EN=1; with the prescaler, see Configuration.
- On a tick with VALUE ≠ 0: VALUE ← VALUE−1.
- On a tick with VALUE = 1 (expiry event): EXPIRED ← 1.
  - PERIODIC=1: VALUE ← LOAD.
  - PERIODIC=0: VALUE ← 0 and EN ← 0.
- On a tick with VALUE = 0: no change and no event.
- Resulting expiry period is LOAD ticks.
- Simultaneous events:
  - EXPIRED set and W1C in the same cycle: set wins.
  - LOAD write and tick in the same cycle: the write wins (VALUE = written value).
  - CTRL write and expiry in the same cycle: CTRL takes the written value, EXPIRED still sets, and the periodic reload uses the old PERIODIC.
- Reset: CTRL, LOAD, VALUE, STATUS, PRESCALE, the prescaler count, `Prdata` and `Tirq` all become 0. A reset asserted mid-access aborts the access with no register update.

## Timing
- Write: the value is visible in register state one cycle after the access-phase edge.
- Read: `Prdata` is loaded on the setup-phase edge (`Psel & !Penable & !Pwrite`), so it is stable throughout the access phase. On every other edge `Prdata` ← 0.
- Read data reflects register state before the setup edge; a tick in that same cycle is not reflected.
- `Tirq` rises one cycle after the expiry-event edge and falls one cycle after the W1C edge, or after an IE=0 write.
- Back-to-back transfers (setup immediately following access) are supported with no idle cycle.

## Configuration
- `TIMER_PRESCALER_EN` defined:
  - PRESCALE is a `PRESC_W`-bit RW register.
  - An internal prescaler count runs while EN=1 and counts 0..PRESCALE.
  - A tick occurs when the count equals PRESCALE; the count then returns to 0.
  - The count is cleared when EN=0 and on any PRESCALE write.
  - Result: tick period is PRESCALE+1 cycles.
- Undefined:
  - Offset 0x10 reads 0 and writes to it are ignored.
  - No prescaler logic is built.
  - Tick occurs every cycle while EN=1.

## Test plan
- Reset, then read all five offsets -> each returns 0 in the access phase; `Tirq`=0.
- Write LOAD=5, then CTRL=0x5 (EN, IE, one-shot) -> VALUE counts 4,3,2,1,0; EXPIRED=1 and EN=0 on the fifth tick; `Tirq`=1 the next cycle; VALUE holds at 0.
- Write LOAD=3, CTRL=0x3 (periodic) -> EXPIRED sets every 3 cycles and VALUE cycles 2,1,3,2,1,3; write STATUS=1 -> EXPIRED clears, `Tirq` falls one cycle later.
- Time the STATUS W1C write to land on the same edge as an expiry -> EXPIRED remains 1.
- Time a LOAD=10 write to land on the same edge as a tick -> VALUE reads 10, not 9; reads of 0x14 and 0x1C return 0.
- With `TIMER_PRESCALER_EN`: PRESCALE=2, LOAD=2, EN=1 -> expiry after 6 cycles. Without the macro: a PRESCALE write is ignored, 0x10 reads 0, and expiry comes after 2 cycles.
